// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, constants and fetch FSM state type for the LEGv8 core
package cpu_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int CNT_W_DEF  = 32;
    localparam int INSTR_W    = 32;
    localparam int PC_INC     = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - PC-relative target adder for branches and ADR
module branch_target #(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              uncond_br,
    input  logic [25:0]       br_addr26,
    input  logic [18:0]       cond_addr19,
    output logic [ADDR_W-1:0] target,
    output logic              is_self
);

    logic [ADDR_W-1:0] sel_ext;
    logic [ADDR_W-1:0] offset;

    // Word offsets are signed; extend the selected field before converting to bytes.
    assign sel_ext = uncond_br ? {{(ADDR_W-26){br_addr26[25]}}, br_addr26}
                               : {{(ADDR_W-19){cond_addr19[18]}}, cond_addr19};
    assign offset  = sel_ext << 2;

    // Sum wraps modulo 2^ADDR_W on purpose.
    assign target  = pc + offset;

    // Zero offset means the branch lands on itself.
    assign is_self = (offset == '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register, next-PC select, run/step/halt control, retired counter
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                CNT_W    = CNT_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              br_taken,
    input  logic              uncond_br,
    input  logic [25:0]       br_addr26,
    input  logic [18:0]       cond_addr19,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              commit,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic              step_q;
    logic              step_rise;
    logic [ADDR_W-1:0] target;
    logic              is_self;
    logic              self_branch;
    logic [ADDR_W-1:0] next_pc;

    branch_target #(
        .ADDR_W(ADDR_W)
    ) u_branch_target (
        .pc         (pc),
        .uncond_br  (uncond_br),
        .br_addr26  (br_addr26),
        .cond_addr19(cond_addr19),
        .target     (target),
        .is_self    (is_self)
    );

    assign pc_plus4    = pc + ADDR_W'(PC_INC);
    assign next_pc     = br_taken ? target : pc_plus4;
    assign self_branch = br_taken & is_self;
    assign step_rise   = step & ~step_q;

    // State register plus step-edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            step_q <= 1'b0;
        end else begin
            state  <= next_state;
            step_q <= step;
        end
    end

    // Next-state and commit decode; run beats a coincident step edge.
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE: begin
                if (run)
                    next_state = RUN;
                else if (step_rise)
                    next_state = STEP;
            end
            RUN, STEP: begin
                commit = 1'b1;
                if (self_branch)
                    next_state = HALTED;
                else if (run)
                    next_state = RUN;
                else
                    next_state = IDLE;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // PC advances only on commit; a self-branch rewrites the same value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_PC;
        else if (commit)
            pc <= next_pc;
    end

    // Retired-instruction count, pinned at all-ones once full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retired <= '0;
        else if (commit && (retired != '1))
            retired <= retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        br_taken = 1'b0;
    logic        uncond_br = 1'b0;
    logic [25:0] br_addr26 = '0;
    logic [18:0] cond_addr19 = '0;

    logic [63:0] pc, pc_plus4, pc_s, pc_plus4_s;
    logic        commit, halted, commit_s, halted_s;
    logic [31:0] retired;
    logic [3:0]  retired_s;

    int n_vec = 0;
    int n_err = 0;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic [63:0] m_pc;
    int          m_mode;
    longint      m_count;
    logic        m_step_prev;

    pc_fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .br_taken   (br_taken),
        .uncond_br  (uncond_br),
        .br_addr26  (br_addr26),
        .cond_addr19(cond_addr19),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .commit     (commit),
        .halted     (halted),
        .retired    (retired)
    );

    pc_fetch_ctrl #(.CNT_W(4)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .br_taken   (br_taken),
        .uncond_br  (uncond_br),
        .br_addr26  (br_addr26),
        .cond_addr19(cond_addr19),
        .pc         (pc_s),
        .pc_plus4   (pc_plus4_s),
        .commit     (commit_s),
        .halted     (halted_s),
        .retired    (retired_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic longint byte_off(input logic u, input logic [25:0] a26, input logic [18:0] a19);
        longint v;
        if (u) begin
            v = longint'(a26);
            if (v >= 64'sd33554432) v = v - 64'sd67108864;
        end else begin
            v = longint'(a19);
            if (v >= 64'sd262144) v = v - 64'sd524288;
        end
        return v * 4;
    endfunction

    function automatic logic [63:0] sat(input longint c, input longint mx);
        return (c > mx) ? mx : c;
    endfunction

    // Reference model of the fetch rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc        <= '0;
            m_mode      <= M_IDLE;
            m_count     <= 0;
            m_step_prev <= 1'b0;
        end else begin
            m_step_prev <= step;
            case (m_mode)
                M_IDLE: begin
                    if (run) m_mode <= M_RUN;
                    else if (step && !m_step_prev) m_mode <= M_STEP;
                end
                M_RUN, M_STEP: begin
                    m_count <= m_count + 1;
                    m_pc    <= br_taken ? m_pc + 64'(byte_off(uncond_br, br_addr26, cond_addr19))
                                        : m_pc + 64'd4;
                    if (br_taken && byte_off(uncond_br, br_addr26, cond_addr19) == 0)
                        m_mode <= M_HALT;
                    else
                        m_mode <= run ? M_RUN : M_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 64'd4);
        check("commit", commit, (m_mode == M_RUN) || (m_mode == M_STEP));
        check("halted", halted, m_mode == M_HALT);
        check("retired", retired, sat(m_count, 64'hFFFF_FFFF));
        check("pc_s", pc_s, m_pc);
        check("commit_s", commit_s, (m_mode == M_RUN) || (m_mode == M_STEP));
        check("retired_s", retired_s, sat(m_count, 15));
    end

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_pc", pc, 64'h0);
        check("rst_retired", retired, 0);
        check("rst_halted", halted, 0);
        check("rst_commit", commit, 0);

        // free run from 0
        run = 1'b1;
        @(negedge clk);
        check("run_first_pc", pc, 64'h0);
        check("run_first_commit", commit, 1);
        repeat (5) @(negedge clk);
        check("run5_pc", pc, 64'd20);
        check("run5_retired", retired, 5);
        check("run5_pc_plus4", pc_plus4, 64'd24);
        repeat (11) @(negedge clk);
        check("run_pc40", pc, 64'h40);

        // backward unconditional, forward conditional
        br_taken  = 1'b1;
        uncond_br = 1'b1;
        br_addr26 = 26'h3FFFFFE;
        @(negedge clk);
        check("br_back_pc", pc, 64'h38);
        uncond_br   = 1'b0;
        cond_addr19 = 19'h00003;
        @(negedge clk);
        check("br_fwd_pc", pc, 64'h44);
        br_taken = 1'b0;
        run      = 1'b0;
        @(negedge clk);
        check("stop_pc", pc, 64'h48);
        check("stop_commit", commit, 0);
        check("stop_retired", retired, 19);

        // single-step pulses
        repeat (2) begin
            step = 1'b1;
            repeat (3) @(negedge clk);
            step = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("step2_pc", pc, 64'h50);
        check("step2_retired", retired, 21);
        step = 1'b1;
        repeat (6) @(negedge clk);
        check("step_held_pc", pc, 64'h54);
        check("step_held_retired", retired, 22);
        step = 1'b0;
        @(negedge clk);

        // run together with a step edge, then branch back to 0x20
        run  = 1'b1;
        step = 1'b1;
        @(negedge clk);
        check("run_step_commit", commit, 1);
        check("run_step_pc", pc, 64'h54);
        br_taken    = 1'b1;
        uncond_br   = 1'b0;
        cond_addr19 = 19'h7FFF3;
        @(negedge clk);
        check("br_to_20_pc", pc, 64'h20);
        check("br_to_20_retired", retired, 23);

        // branch-to-self halts
        uncond_br = 1'b1;
        br_addr26 = '0;
        @(negedge clk);
        check("halt_flag", halted, 1);
        check("halt_pc", pc, 64'h20);
        check("halt_retired", retired, 24);
        check("halt_commit", commit, 0);
        for (int i = 0; i < 8; i++) begin
            run      = i[0];
            step     = i[1];
            br_taken = i[2];
            @(negedge clk);
        end
        check("halt_hold_pc", pc, 64'h20);
        check("halt_hold_retired", retired, 24);
        check("halt_hold_flag", halted, 1);
        check("small_saturated", retired_s, 4'hF);

        // reset clears halt
        run      = 1'b0;
        step     = 1'b0;
        br_taken = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rerst_halted", halted, 0);

        // reach 0x100, then reset asynchronously during STEP
        run       = 1'b1;
        br_taken  = 1'b1;
        uncond_br = 1'b1;
        br_addr26 = 26'h40;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("jump_pc", pc, 64'h100);
        check("jump_commit", commit, 0);
        br_taken = 1'b0;
        step     = 1'b1;
        @(negedge clk);
        check("in_step_commit", commit, 1);
        check("in_step_pc", pc, 64'h100);
        #2 reset = 1'b1;
        #1;
        check("async_pc", pc, 64'h0);
        check("async_retired", retired, 0);
        check("async_halted", halted, 0);
        check("async_commit", commit, 0);
        step = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_pc", pc, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
